exec_mem_responder: RTL
=======================

// Module: exec_mem_responder
// PURPOSE
//  Memory-side responder for the execution unit's read/write request interface.
//  Holds a 2^ADDR_WIDTH x DATA_WIDTH word array and commits exec_wr_* writes.
//  Answers exec_rd_* reads with exec_rd_data after a fixed, parameterised latency.
//  Also provides a testbench backdoor preload port and transaction counters for scoreboarding.
// PARAMETERS
//  ADDR_WIDTH  12  address width in bits; array depth is 2**ADDR_WIDTH
//  DATA_WIDTH  12  word width in bits
//  RD_LATENCY  1   cycles from read-request sample to exec_rd_data/exec_rd_valid; legal 1..4
//  CNT_WIDTH   16  width of the transaction counters
// PORTS
//  clk            in   1           free-running clock; all logic on posedge
//  reset          in   1           synchronous, active-high reset
//  exec_rd_req    in   1           read request, sampled every posedge
//  exec_rd_addr   in   ADDR_WIDTH  read address, valid with exec_rd_req
//  exec_rd_data   out  DATA_WIDTH  read data
//  exec_rd_valid  out  1           one-cycle pulse; exec_rd_data valid
//  exec_wr_req    in   1           write request, sampled every posedge
//  exec_wr_addr   in   ADDR_WIDTH  write address
//  exec_wr_data   in   DATA_WIDTH  write data
//  load_en        in   1           backdoor preload strobe (testbench only)
//  load_addr      in   ADDR_WIDTH  preload address
//  load_data      in   DATA_WIDTH  preload data
//  rd_count       out  CNT_WIDTH   reads accepted since reset
//  wr_count       out  CNT_WIDTH   writes committed since reset
//  collision      out  1           sticky: rd and wr to same addr in the same cycle
// BEHAVIOUR
//  - Reset (clk edge with reset=1):
//    - exec_rd_data=0, exec_rd_valid=0, rd_count=0, wr_count=0, collision=0.
//    - Read pipeline flushed; in-flight reads are dropped and produce no valid pulse.
//    - Array contents are NOT cleared.
//    - While reset=1, exec_* and load_* requests are ignored.
//  - Read pipeline (RD_LATENCY stages):
//    - exec_rd_req=1 at edge N captures the array word at exec_rd_addr.
//    - exec_rd_data is driven and exec_rd_valid=1 after edge N+RD_LATENCY-1 (RD_LATENCY=1: visible right after edge N).
//    - Fully pipelined: back-to-back reads every cycle are accepted and return in order.
//    - No stall or backpressure exists.
//  - exec_rd_data holds its last value when exec_rd_valid=0.
//  - Write: exec_wr_req=1 at an edge writes exec_wr_data to exec_wr_addr at that edge.
//    - No response; the write is visible to reads sampled at the next edge or later.
//  - Same-cycle read and write:
//    - Read returns OLD data (read-before-write).
//    - If the addresses match, collision sets and stays set until reset.
//  - Backdoor load: load_en=1 writes load_data at that edge.
//    - If exec_wr_req=1 in the same cycle, the exec write wins at an equal address; both commit at different addresses.
//    - Loads do not bump wr_count.
//  - Counters:
//    - rd_count +1 per accepted exec_rd_req; wr_count +1 per exec_wr_req.
//    - Both wrap modulo 2**CNT_WIDTH, with no saturation.
//  - Addresses wrap naturally in ADDR_WIDTH bits; no out-of-range case exists.
//  - X/Z on exec_rd_req or exec_wr_req outside reset: $error in simulation (translate_off); treated as 0.
//  - Out-of-range RD_LATENCY: elaboration-time $fatal.
// TESTING
//  - Reset:
//    - Assert reset mid-stream with 2 reads in flight (RD_LATENCY=3).
//    - Required: no exec_rd_valid pulse afterwards, counters=0, data at preloaded addrs unchanged.
//  - Preload/read:
//    - load 0o1234 @0o0100; read 0o0100.
//    - Required: exec_rd_valid exactly RD_LATENCY cycles later with data 0o1234; rd_count=1.
//  - Write-then-read:
//    - wr 0o7777 @0o0200 at edge N; rd 0o0200 at edge N+1.
//    - Required: returns 0o7777; wr_count=1.
//  - Collision:
//    - Preload 0o0005 @0o0300; same cycle rd+wr @0o0300 with data 0o0006.
//    - Required: read returns 0o0005, collision=1, next read returns 0o0006.
//  - Pipelining:
//    - RD_LATENCY=4, reads to addrs 1,2,3,4 on consecutive cycles.
//    - Required: 4 consecutive valid pulses with in-order data; rd_count=4.
//  - Counter wrap:
//    - CNT_WIDTH=4, 17 writes.
//    - Required: wr_count=1; load_en+exec_wr same addr -> exec data stored.

Source files
------------

// File: rtl/exec_mem_responder.sv
// ============================================================================
// Module      : exec_mem_responder
// Description : Memory-side responder for the execution unit. Word array with
//               exec write port, fixed-latency pipelined read port, backdoor
//               preload port and scoreboarding counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  collision
);

    localparam int                   c_depth   = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_ld_fire;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_last_vld;
    logic [DATA_WIDTH-1:0] w_last_data;

    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic [CNT_WIDTH-1:0]  r_wr_count;
    logic                  r_collision;

    // Requests are qualified through if-statements so an unknown strobe reads as 0.
    always_comb begin
        w_rd_fire = 1'b0;
        w_wr_fire = 1'b0;
        w_ld_fire = 1'b0;
        if (!reset) begin
            if (exec_rd_req) w_rd_fire = 1'b1;
            if (exec_wr_req) w_wr_fire = 1'b1;
            if (load_en)     w_ld_fire = 1'b1;
        end
    end

    // Array read happens before this edge's writes land: read-before-write.
    assign w_rd_word = r_mem[exec_rd_addr];

    // The exec write is applied last so it wins over a load to the same address.
    always_ff @(posedge clk) begin
        if (w_ld_fire) r_mem[load_addr]    <= load_data;
        if (w_wr_fire) r_mem[exec_wr_addr] <= exec_wr_data;
    end

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
            $fatal(1, "exec_mem_responder: RD_LATENCY must be in 1..4");
        end else if (RD_LATENCY == 1) begin : g_lat_one
            assign w_last_vld  = w_rd_fire;
            assign w_last_data = w_rd_word;
        end else begin : g_lat_pipe
            logic [RD_LATENCY-2:0] r_vld;
            logic [DATA_WIDTH-1:0] r_dat [0:RD_LATENCY-2];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_rd_fire;
                    for (int i = 1; i < RD_LATENCY-1; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_dat[0] <= w_rd_word;
                for (int i = 1; i < RD_LATENCY-1; i++) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end

            assign w_last_vld  = r_vld[RD_LATENCY-2];
            assign w_last_data = r_dat[RD_LATENCY-2];
        end
    endgenerate

    // Output stage: data only moves on a valid beat, otherwise it holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_last_vld;
            if (w_last_vld) r_rd_data <= w_last_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_collision <= 1'b0;
        end else begin
            if (w_rd_fire) r_rd_count <= r_rd_count + c_cnt_one;
            if (w_wr_fire) r_wr_count <= r_wr_count + c_cnt_one;
            if (w_rd_fire && w_wr_fire && (exec_rd_addr == exec_wr_addr)) begin
                r_collision <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(exec_rd_req))
                else $error("exec_mem_responder: exec_rd_req is X/Z");
            assert (!$isunknown(exec_wr_req))
                else $error("exec_mem_responder: exec_wr_req is X/Z");
        end
    end
`endif

    assign exec_rd_valid = r_rd_valid;
    assign exec_rd_data  = r_rd_data;
    assign rd_count      = r_rd_count;
    assign wr_count      = r_wr_count;
    assign collision     = r_collision;

endmodule

`default_nettype wire
